vga_timing_gen: RTL and testbench

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

---
 rtl/vga_timing_gen.sv | 115 +++++++++++
 tb/tb_vga_timing_gen.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
// VGA raster timing: position counters plus sync/blank flags registered from next-state counts (zero skew).
// en=0 freezes every output; define VGA_TIMING_FRAME_CNT_EN to add the 16-bit frame_count output.
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter bit H_SYNC_POL = 1'b0,
    parameter bit V_SYNC_POL = 1'b0,
    parameter int CNT_W      = 16
) (
    input  logic             clk_25Mhz,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] h_count_value,
    output logic [CNT_W-1:0] v_count_value,
    output logic             hsync,
    output logic             vsync,
    output logic             video_on,
    output logic             line_end,
    output logic             frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [15:0]      frame_count
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] H_VIS    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_VIS    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [CNT_W-1:0] r_h;
    logic [CNT_W-1:0] r_v;
    logic             r_hsync;
    logic             r_vsync;
    logic             r_video_on;
    logic             r_line_end;
    logic             r_frame_start;

    logic [CNT_W-1:0] w_h_nxt;
    logic [CNT_W-1:0] w_v_nxt;
    logic             w_h_wrap;
    logic             w_frame_wrap;
    logic             w_hsync_nxt;
    logic             w_vsync_nxt;
    logic             w_video_nxt;
    logic             w_line_end_nxt;

    assign w_h_wrap     = (r_h == H_LAST);
    assign w_frame_wrap = w_h_wrap && (r_v == V_LAST);
    assign w_h_nxt      = w_h_wrap ? '0 : r_h + CNT_W'(1);
    assign w_v_nxt      = !w_h_wrap    ? r_v :
                          w_frame_wrap ? '0  : r_v + CNT_W'(1);

    // Flags decode the position the counters are about to hold, so both land in the same cycle.
    assign w_hsync_nxt    = ((w_h_nxt >= HS_FIRST) && (w_h_nxt <= HS_LAST)) ? H_SYNC_POL : ~H_SYNC_POL;
    assign w_vsync_nxt    = ((w_v_nxt >= VS_FIRST) && (w_v_nxt <= VS_LAST)) ? V_SYNC_POL : ~V_SYNC_POL;
    assign w_video_nxt    = (w_h_nxt < H_VIS) && (w_v_nxt < V_VIS);
    assign w_line_end_nxt = (w_h_nxt == H_LAST);

    always_ff @(posedge clk_25Mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_h           <= '0;
            r_v           <= '0;
            r_hsync       <= ~H_SYNC_POL;
            r_vsync       <= ~V_SYNC_POL;
            r_video_on    <= 1'b0;
            r_line_end    <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (en) begin
            r_h           <= w_h_nxt;
            r_v           <= w_v_nxt;
            r_hsync       <= w_hsync_nxt;
            r_vsync       <= w_vsync_nxt;
            r_video_on    <= w_video_nxt;
            r_line_end    <= w_line_end_nxt;
            r_frame_start <= w_frame_wrap;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    always_ff @(posedge clk_25Mhz or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
        end else if (en && w_frame_wrap) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign frame_count = r_frame_cnt;
`endif

    assign h_count_value = r_h;
    assign v_count_value = r_v;
    assign hsync         = r_hsync;
    assign vsync         = r_vsync;
    assign video_on      = r_video_on;
    assign line_end      = r_line_end;
    assign frame_start   = r_frame_start;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a default-size and a tiny-raster instance checked every cycle against
// a model that derives the expected raster position from the count of enabled edges since reset.
module tb_vga_timing_gen;

    localparam int S_HA = 4, S_HF = 1, S_HS = 2, S_HB = 1;
    localparam int S_VA = 3, S_VF = 1, S_VS = 1, S_VB = 1;

    logic        clk = 1'b0;
    logic        rst_d, en_d, rst_s, en_s;
    logic [15:0] h_d, v_d, h_s, v_s;
    logic        hs_d, vs_d, vo_d, le_d, fs_d;
    logic        hs_s, vs_s, vo_s, le_s, fs_s;
`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] fc_d, fc_s;
`endif

    int pass_cnt = 0;
    int total_cnt = 0;
    int n_d = 0;
    int n_s = 0;
    bit chk_on = 1'b0;

    always #5 clk = ~clk;

    vga_timing_gen dut_d (
        .clk_25Mhz     (clk),
        .rst_n         (rst_d),
        .en            (en_d),
        .h_count_value (h_d),
        .v_count_value (v_d),
        .hsync         (hs_d),
        .vsync         (vs_d),
        .video_on      (vo_d),
        .line_end      (le_d),
        .frame_start   (fs_d)
`ifdef VGA_TIMING_FRAME_CNT_EN
        ,
        .frame_count   (fc_d)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
        .H_SYNC_POL(1'b1), .V_SYNC_POL(1'b0), .CNT_W(16)
    ) dut_s (
        .clk_25Mhz     (clk),
        .rst_n         (rst_s),
        .en            (en_s),
        .h_count_value (h_s),
        .v_count_value (v_s),
        .hsync         (hs_s),
        .vsync         (vs_s),
        .video_on      (vo_s),
        .line_end      (le_s),
        .frame_start   (fs_s)
`ifdef VGA_TIMING_FRAME_CNT_EN
        ,
        .frame_count   (fc_s)
`endif
    );

    // Reference state: number of enabled edges since the last reset.
    always @(posedge clk or negedge rst_d) begin
        if (!rst_d) n_d <= 0;
        else if (en_d) n_d <= n_d + 1;
    end

    always @(posedge clk or negedge rst_s) begin
        if (!rst_s) n_s <= 0;
        else if (en_s) n_s <= n_s + 1;
    end

    task automatic chk(input string name, input int act, input int exp);
        total_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic model_check(input string tag, input int n,
                               input int ha, input int hf, input int hsw, input int hb,
                               input int va, input int vf, input int vsw, input int vb,
                               input int hp, input int vp,
                               input int h, input int v, input int hsy, input int vsy,
                               input int vo, input int le, input int fs);
        int ht, vt, p, eh, ev;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        p  = n % (ht * vt);
        eh = p % ht;
        ev = p / ht;
        chk({tag, ".h"}, h, eh);
        chk({tag, ".v"}, v, ev);
        chk({tag, ".hsync"}, hsy, (eh >= ha + hf && eh <= ha + hf + hsw - 1) ? hp : 1 - hp);
        chk({tag, ".vsync"}, vsy, (ev >= va + vf && ev <= va + vf + vsw - 1) ? vp : 1 - vp);
        chk({tag, ".video_on"}, vo, (n > 0 && eh < ha && ev < va) ? 1 : 0);
        chk({tag, ".line_end"}, le, (eh == ht - 1) ? 1 : 0);
        chk({tag, ".frame_start"}, fs, (n > 0 && p == 0) ? 1 : 0);
    endtask

    always @(negedge clk) begin
        if (chk_on) begin
            model_check("d", n_d, 640, 16, 96, 48, 480, 10, 2, 33, 0, 0,
                        int'(h_d), int'(v_d), int'(hs_d), int'(vs_d), int'(vo_d), int'(le_d), int'(fs_d));
            model_check("s", n_s, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB, 1, 0,
                        int'(h_s), int'(v_s), int'(hs_s), int'(vs_s), int'(vo_s), int'(le_s), int'(fs_s));
`ifdef VGA_TIMING_FRAME_CNT_EN
            chk("d.frame_count", int'(fc_d), (n_d / (800 * 525)) % 65536);
            chk("s.frame_count", int'(fc_s), (n_s / 48) % 65536);
`endif
        end
    end

    task automatic step(input int k);
        repeat (k) @(posedge clk);
        #2;
    endtask

    task automatic chk_reset_d(input string tag);
        chk({tag, ".h"}, int'(h_d), 0);
        chk({tag, ".v"}, int'(v_d), 0);
        chk({tag, ".hsync"}, int'(hs_d), 1);
        chk({tag, ".vsync"}, int'(vs_d), 1);
        chk({tag, ".video_on"}, int'(vo_d), 0);
        chk({tag, ".line_end"}, int'(le_d), 0);
        chk({tag, ".frame_start"}, int'(fs_d), 0);
    endtask

    task automatic chk_reset_s(input string tag);
        chk({tag, ".h"}, int'(h_s), 0);
        chk({tag, ".v"}, int'(v_s), 0);
        chk({tag, ".hsync"}, int'(hs_s), 0);
        chk({tag, ".vsync"}, int'(vs_s), 1);
        chk({tag, ".video_on"}, int'(vo_s), 0);
        chk({tag, ".line_end"}, int'(le_s), 0);
        chk({tag, ".frame_start"}, int'(fs_s), 0);
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk({tag, ".frame_count"}, int'(fc_s), 0);
`endif
    endtask

    initial begin
        int vo_cnt, hs_cnt, vs_cnt, fs_cnt;
        rst_d = 1'b1; rst_s = 1'b1; en_d = 1'b0; en_s = 1'b0;
        #1 rst_d = 1'b0; rst_s = 1'b0;
        #1 chk_on = 1'b1;
        step(3);
        chk_reset_d("reset_d");
        chk_reset_s("reset_s");
        rst_d = 1'b1; rst_s = 1'b1; en_d = 1'b1; en_s = 1'b1;

        // Default raster: horizontal sync window, line end and line advance.
        step(655);
        chk("h_655", int'(h_d), 655);
        chk("hsync_655", int'(hs_d), 1);
        step(1);
        chk("hsync_656", int'(hs_d), 0);
        step(95);
        chk("hsync_751", int'(hs_d), 0);
        step(1);
        chk("hsync_752", int'(hs_d), 1);
        step(46);
        chk("line_end_798", int'(le_d), 0);
        step(1);
        chk("line_end_799", int'(le_d), 1);
        chk("v_at_799", int'(v_d), 0);
        step(1);
        chk("h_wrap", int'(h_d), 0);
        chk("v_advance", int'(v_d), 1);
        chk("line_end_after_wrap", int'(le_d), 0);

        // en pattern 1,0,0,1 starting at h=100.
        step(100);
        chk("h_100", int'(h_d), 100);
        step(1);
        chk("en1_h", int'(h_d), 101);
        en_d = 1'b0;
        step(1);
        chk("en0a_h", int'(h_d), 101);
        step(1);
        chk("en0b_h", int'(h_d), 101);
        chk("en0_hsync", int'(hs_d), 1);
        chk("en0_vsync", int'(vs_d), 1);
        chk("en0_video_on", int'(vo_d), 1);
        chk("en0_line_end", int'(le_d), 0);
        chk("en0_frame_start", int'(fs_d), 0);
        en_d = 1'b1;
        step(1);
        chk("en1b_h", int'(h_d), 102);

        // Random enables with occasional asynchronous resets of the small raster.
        repeat (3000) begin
            en_d = ($urandom_range(0, 3) != 0);
            en_s = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) == 0) begin
                rst_s = 1'b0;
                #1 rst_s = 1'b1;
            end
            step(1);
        end

        // Asynchronous reset mid-frame reaches reset values before the next edge.
        en_d = 1'b1; en_s = 1'b1;
        step(20);
        rst_d = 1'b0; rst_s = 1'b0;
        #1;
        chk_reset_d("async_d");
        chk_reset_s("async_s");
        rst_d = 1'b1; rst_s = 1'b1;
        step(1);
        chk("post_rst_d_h", int'(h_d), 1);
        chk("post_rst_d_v", int'(v_d), 0);
        chk("post_rst_d_video_on", int'(vo_d), 1);
        chk("post_rst_s_h", int'(h_s), 1);
        chk("post_rst_s_v", int'(v_s), 0);
        chk("post_rst_s_video_on", int'(vo_s), 1);

        // Small raster frame statistics over two 48-cycle frames.
        rst_s = 1'b0;
        #1 rst_s = 1'b1;
        vo_cnt = int'(vo_s); hs_cnt = int'(hs_s); vs_cnt = int'(!vs_s); fs_cnt = 0;
        repeat (47) begin
            step(1);
            vo_cnt += int'(vo_s); hs_cnt += int'(hs_s); vs_cnt += int'(!vs_s); fs_cnt += int'(fs_s);
        end
        chk("frame1_video_on_cycles", vo_cnt, 11);
        chk("frame1_hsync_high_cycles", hs_cnt, 12);
        chk("frame1_vsync_low_cycles", vs_cnt, 8);
        vo_cnt = 0; hs_cnt = 0; vs_cnt = 0;
        repeat (48) begin
            step(1);
            vo_cnt += int'(vo_s); hs_cnt += int'(hs_s); vs_cnt += int'(!vs_s); fs_cnt += int'(fs_s);
        end
        chk("frame2_video_on_cycles", vo_cnt, 12);
        chk("frame2_hsync_high_cycles", hs_cnt, 12);
        chk("frame2_vsync_low_cycles", vs_cnt, 8);
        step(1);
        fs_cnt += int'(fs_s);
        chk("frame_start_pulses_96", fs_cnt, 2);
`ifdef VGA_TIMING_FRAME_CNT_EN
        chk("frame_count_96", int'(fc_s), 2);
`endif

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
